// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl : 4-digit common-anode 7-segment scan controller with
// double-buffered hex digits and blanking between slots.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       EN,
   input  logic       LOAD,
   input  logic [3:0] D0,
   input  logic [3:0] D1,
   input  logic [3:0] D2,
   input  logic [3:0] D3,
   input  logic [3:0] BLANK_DIG,
   output logic [6:0] SEG_A,
   output logic [6:0] SEG_B,
   output logic [6:0] SEG_C,
   output logic [6:0] SEG_D,
   output logic [1:0] S,
   output logic [3:0] AN,
   output logic       FRAME
);

   localparam int            CW         = $clog2(DIV);
   localparam logic [CW-1:0] LAST       = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    din  [4];
   logic [3:0]    pend [4];
   logic [3:0]    act  [4];
   logic          wrap;
   logic          xfer;
   logic          direct;

   assign din[0] = D0;
   assign din[1] = D1;
   assign din[2] = D2;
   assign din[3] = D3;

   // Active digits only change at a frame boundary or when the scan starts.
   assign wrap   = EN && (state == DRIVE) && (cnt == LAST) && (S == 2'd3);
   assign xfer   = wrap || (EN && (state == IDLE));
   assign direct = LOAD && (xfer || (state == IDLE));

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'h0: p = 7'b1000000;
         4'h1: p = 7'b1111001;
         4'h2: p = 7'b0100100;
         4'h3: p = 7'b0110000;
         4'h4: p = 7'b0011001;
         4'h5: p = 7'b0010010;
         4'h6: p = 7'b0000010;
         4'h7: p = 7'b1111000;
         4'h8: p = 7'b0000000;
         4'h9: p = 7'b0010000;
         4'hA: p = 7'b0001000;
         4'hB: p = 7'b0000011;
         4'hC: p = 7'b1000110;
         4'hD: p = 7'b0100001;
         4'hE: p = 7'b0000110;
         default: p = 7'b0001110;
      endcase
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         S     <= 2'd0;
         AN    <= 4'b1111;
         FRAME <= 1'b0;
      end else if (!EN) begin
         state <= IDLE;
         cnt   <= '0;
         S     <= 2'd0;
         AN    <= 4'b1111;
         FRAME <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= BLANK;
               cnt   <= '0;
               S     <= 2'd0;
               AN    <= 4'b1111;
               FRAME <= 1'b0;
            end
            BLANK: begin
               FRAME <= 1'b0;
               cnt   <= cnt + 1'b1;
               if (cnt == BLANK_LAST) begin
                  state <= DRIVE;
                  AN    <= ~(4'b0001 << S);
               end else begin
                  AN    <= 4'b1111;
               end
            end
            DRIVE: begin
               if (cnt == LAST) begin
                  // Select advances only while the anodes are dark.
                  state <= BLANK;
                  cnt   <= '0;
                  S     <= S + 2'd1;
                  AN    <= 4'b1111;
                  FRAME <= (S == 2'd3);
               end else begin
                  cnt   <= cnt + 1'b1;
                  AN    <= ~(4'b0001 << S);
                  FRAME <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               S     <= 2'd0;
               AN    <= 4'b1111;
               FRAME <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            pend[i] <= 4'h0;
            act[i]  <= 4'h0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (LOAD)
               pend[i] <= din[i];
            if (direct)
               act[i] <= din[i];
            else if (xfer)
               act[i] <= pend[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         SEG_A <= 7'b1111111;
         SEG_B <= 7'b1111111;
         SEG_C <= 7'b1111111;
         SEG_D <= 7'b1111111;
      end else begin
         SEG_A <= BLANK_DIG[0] ? 7'b1111111 : hex7(act[0]);
         SEG_B <= BLANK_DIG[1] ? 7'b1111111 : hex7(act[1]);
         SEG_C <= BLANK_DIG[2] ? 7'b1111111 : hex7(act[2]);
         SEG_D <= BLANK_DIG[3] ? 7'b1111111 : hex7(act[3]);
      end
   end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 500: cycles at the start of each slot with all anodes off (legal range 1..DIV-2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port EN, input, 1 bit: scan enable.
REQ-006 SHALL have port LOAD, input, 1 bit: one-cycle strobe that captures D0..D3.
REQ-007 SHALL have ports D0, D1, D2, D3, inputs, 4 bits each: hex digit values for digits 0..3.
REQ-008 SHALL have port BLANK_DIG, input, 4 bits: bit i=1 blanks digit i.
REQ-009 SHALL have ports SEG_A, SEG_B, SEG_C, SEG_D, outputs, 7 bits each: active-low segment patterns {g,f,e,d,c,b,a} for digits 0..3, feeding the downstream 4:1 mux inputs A..D.
REQ-010 SHALL have port S, output, 2 bits: digit select driven to the downstream mux select.
REQ-011 SHALL have port AN, output, 4 bits: active-low common-anode enables; AN[i]=0 lights digit i.
REQ-012 SHALL have port FRAME, output, 1 bit: one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-013 SHALL use the states IDLE, BLANK and DRIVE, with a slot counter cnt in the range 0..DIV-1.
REQ-014 In IDLE with EN=1, SHALL move to BLANK with S=0 and cnt=0 on the next edge.
REQ-015 In BLANK, SHALL hold AN=4'b1111 and increment cnt, moving to DRIVE when cnt=BLANK_CYC-1.
REQ-016 In DRIVE, SHALL drive AN as all ones except AN[S]=0, and increment cnt.
REQ-017 In DRIVE at cnt=DIV-1, SHALL set cnt=0 and S=S+1 modulo 4 (3 wraps to 0), then return to BLANK; each slot is therefore exactly DIV cycles.
REQ-018 SHALL pulse FRAME high for exactly one cycle, registered, on the cycle after the edge on which S wraps from 3 to 0.
REQ-019 SHALL hold S stable throughout BLANK and DRIVE of a slot; S SHALL change only at a slot boundary, while AN=4'b1111 (no ghosting).
REQ-020 If EN=0 in any state, SHALL go to IDLE on the next edge with AN=4'b1111, S=0 and cnt=0, and SHALL NOT pulse FRAME.
REQ-021 LOAD=1 SHALL capture D0..D3 into a pending register.
REQ-022 SHALL copy the pending register into the active register on the edge where S wraps from 3 to 0, and on IDLE-to-BLANK entry.
REQ-023 If LOAD coincides with a transfer edge, SHALL write the same-cycle D0..D3 into both the pending and active registers.
REQ-024 In IDLE, LOAD SHALL write both the pending and active registers directly.
REQ-025 SHALL register SEG_x from the active digit x, updating one cycle after the active register changes.
REQ-026 Decode examples (all 16 hex values SHALL be decoded):
- 0 -> 1000000
- 1 -> 1111001
- 8 -> 0000000
- A -> 0001000
- F -> 0001110
REQ-027 BLANK_DIG[i]=1 SHALL force the corresponding SEG output to 7'b1111111 one cycle later, independent of the state.
REQ-028 SEG_A..SEG_D SHALL be valid in every state, including IDLE.

Reset
REQ-029 rst=1 SHALL, at the clock edge, set:
- state = IDLE
- cnt = 0
- S = 0
- AN = 4'b1111
- FRAME = 0
- pending and active digit registers = 0
- SEG_A..SEG_D = 7'b1111111
REQ-030 rst SHALL take priority over EN and LOAD.
REQ-031 Reset asserted mid-slot SHALL turn all anodes off on that edge.
REQ-032 After rst deasserts, SEG outputs SHALL show the decoded 0 pattern (1000000) one cycle later, unless blanked.

Verification (DIV=8, BLANK_CYC=2)
REQ-033 Reset, then EN=1 for 40 cycles -> per slot 2 cycles AN=1111 then 6 cycles AN[S]=0; S sequence 0,1,2,3,0; FRAME high exactly once, the cycle after S 3->0.
REQ-034 In IDLE: LOAD with D0=1, D1=8, D2=A, D3=F -> next cycle SEG_A=1111001, SEG_B=0000000, SEG_C=0001000, SEG_D=0001110.
REQ-035 While scanning at S=1: LOAD D0=0 -> SEG_A unchanged until the edge where S wraps 3->0, then 1000000 one cycle later; LOAD coinciding with the wrap edge -> new value applied on that wrap.
REQ-036 EN dropped during DRIVE of slot 2 -> next cycle AN=1111, S=0, no FRAME; EN re-raised -> restarts at slot 0 BLANK.
REQ-037 rst pulsed mid-DRIVE with AN=1011 -> AN=1111, SEG all 1111111, S=0 after the edge.
REQ-038 BLANK_DIG=4'b0100 during scan -> SEG_C=1111111 the next cycle; AN timing unchanged.
